traffic_phase_sequencer: RTL

//  Parametrised traffic-light phase sequencer with a dot-matrix row scanner, all on one clock.

---
 rtl/traffic_phase_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - traffic-light phase sequencer with dot-matrix row scanner
//
// Purpose:
//   Cycles GREEN -> YELLOW -> RED -> GREEN, counting each phase down on sec_tick.
//   Supports hold, pedestrian-request shortening of GREEN and an emergency flash
//   mode. A free-running row scanner advances on scan_tick for the matrix driver.
//
// Ports:
//   clk1        in   1      system clock, posedge
//   reset       in   1      asynchronous active-low reset
//   sec_tick    in   1      countdown time-base strobe
//   scan_tick   in   1      row-scan time-base strobe
//   hold        in   1      freeze phase and countdown
//   emerg       in   1      emergency flash mode request
//   ped_req     in   1      pedestrian button (level or pulse)
//   state       out  2      0 GREEN, 1 YELLOW, 2 RED, 3 EMERG
//   count_down  out  CNT_W  remaining seconds in the phase
//   row_cnt     out  ROW_W  active matrix row
//   flash       out  1      emergency blink phase, 0 outside EMERG
//   phase_done  out  1      one-cycle pulse on every phase change
//   ped_ack     out  1      one-cycle pulse when a served request enters RED

module traffic_phase_sequencer #(
    parameter int CNT_W       = 4,
    parameter int T_GREEN     = 15,
    parameter int T_YELLOW    = 5,
    parameter int T_RED       = 10,
    parameter int T_MIN_GREEN = 3,
    parameter int ROWS        = 8,
    parameter int ROW_W       = 3
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             sec_tick,
    input  logic             scan_tick,
    input  logic             hold,
    input  logic             emerg,
    input  logic             ped_req,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] count_down,
    output logic [ROW_W-1:0] row_cnt,
    output logic             flash,
    output logic             phase_done,
    output logic             ped_ack
);

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_RED    = 2'd2,
        PH_EMERG  = 2'd3
    } phase_t;

    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] LD_RED    = CNT_W'(T_RED);
    localparam logic [CNT_W-1:0] LD_MIN    = CNT_W'(T_MIN_GREEN);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);

    phase_t cur;
    logic   ped_pending;

    assign state = cur;

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            cur         <= PH_GREEN;
            count_down  <= LD_GREEN;
            flash       <= 1'b0;
            phase_done  <= 1'b0;
            ped_ack     <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            phase_done <= 1'b0;
            ped_ack    <= 1'b0;
            if (emerg) begin
                if (cur != PH_EMERG) begin
                    cur         <= PH_EMERG;
                    count_down  <= CNT_ZERO;
                    flash       <= 1'b0;
                    phase_done  <= 1'b1;
                    ped_pending <= 1'b0;
                end else if (sec_tick) begin
                    flash <= ~flash;
                end
            end else if (cur == PH_EMERG) begin
                // Leaving emergency always lands in RED so cross traffic clears first.
                cur        <= PH_RED;
                count_down <= LD_RED;
                flash      <= 1'b0;
                phase_done <= 1'b1;
            end else begin
                // Requests are latched even while held; only GREEN accepts them.
                if (ped_req && cur == PH_GREEN)
                    ped_pending <= 1'b1;
                if (!hold && sec_tick) begin
                    case (cur)
                        PH_GREEN: begin
                            if (count_down == CNT_ZERO) begin
                                cur        <= PH_YELLOW;
                                count_down <= LD_YELLOW;
                                phase_done <= 1'b1;
                            end else if (ped_pending && count_down > LD_MIN) begin
                                count_down <= LD_MIN;
                            end else begin
                                count_down <= count_down - CNT_ONE;
                            end
                        end
                        PH_YELLOW: begin
                            if (count_down == CNT_ZERO) begin
                                cur        <= PH_RED;
                                count_down <= LD_RED;
                                phase_done <= 1'b1;
                                if (ped_pending) begin
                                    ped_ack     <= 1'b1;
                                    ped_pending <= 1'b0;
                                end
                            end else begin
                                count_down <= count_down - CNT_ONE;
                            end
                        end
                        PH_RED: begin
                            if (count_down == CNT_ZERO) begin
                                cur        <= PH_GREEN;
                                count_down <= LD_GREEN;
                                phase_done <= 1'b1;
                            end else begin
                                count_down <= count_down - CNT_ONE;
                            end
                        end
                        default: begin
                            cur        <= PH_GREEN;
                            count_down <= LD_GREEN;
                        end
                    endcase
                end
            end
        end
    end

    // Row scan runs regardless of phase, hold or emergency.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            row_cnt <= '0;
        end else if (scan_tick) begin
            if (row_cnt == ROW_LAST)
                row_cnt <= '0;
            else
                row_cnt <= row_cnt + ROW_ONE;
        end
    end

endmodule
